test_aggregator: RTL and testbench

- CI harness block directly downstream of the per-operator self-checking test modules (e.g. the add/sub/mul test instances).
- Consumes each test's fail/finish pair, latches sticky per-test results and enforces a global cycle timeout.
- Produces one registered verdict (done/pass/timeout) plus diagnostic masks for the top-level CI testbench.

---
 rtl/test_pkg.sv | 20 ++
 rtl/test_timer.sv | 24 ++
 rtl/test_aggregator.sv | 99 +++++++++
 tb/tb_test_aggregator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/test_pkg.sv
// Shared definitions for the CI test aggregator: FSM state encoding and an
// index-width helper used to size per-test index ports.
package test_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DONE    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN     = ST_RUN,
        S_DONE    = ST_DONE,
        S_TIMEOUT = ST_TIMEOUT
    } state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_timer.sv
// Saturating run-cycle counter with synchronous clear; expired flags the last
// count before the timeout verdict.
module test_timer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_aggregator.sv
// Collects fail/finish flags from the per-operator test instances, keeps sticky
// per-test results and issues a single registered done/pass/timeout verdict.
module test_aggregator
    import test_pkg::*;
#(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_TESTS-1:0]          fail,
    input  logic [NUM_TESTS-1:0]          finish,
    output logic [NUM_TESTS-1:0]          fail_mask,
    output logic [NUM_TESTS-1:0]          finish_mask,
    output logic                          first_fail_valid,
    output logic [idx_w(NUM_TESTS)-1:0]   first_fail_idx,
    output logic [CNT_W-1:0]              cycles,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout
);

    localparam int IDX_W = idx_w(NUM_TESTS);

    state_t               state;
    state_t               next_state;
    logic [NUM_TESTS-1:0] next_fin;
    logic [NUM_TESTS-1:0] next_fail;
    logic [IDX_W-1:0]     low_idx;
    logic                 in_run;
    logic                 expired;

    assign in_run = (state == S_RUN);

    test_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (in_run),
        .count   (cycles),
        .expired (expired)
    );

    // Completion outranks timeout when the last finish lands on the final edge.
    always_comb begin
        next_fin   = finish_mask | finish;
        next_fail  = fail_mask | fail;
        next_state = state;
        if (in_run) begin
            if (&next_fin) begin
                next_state = S_DONE;
            end else if (expired) begin
                next_state = S_TIMEOUT;
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (fail[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fail_mask        <= '0;
            finish_mask      <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            pass             <= 1'b0;
        end else if (in_run) begin
            fail_mask   <= next_fail;
            finish_mask <= next_fin;
            if (!first_fail_valid && (fail != '0)) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= low_idx;
            end
            pass <= (next_state == S_DONE) && (next_fail == '0);
        end
    end

    assign done    = (state != S_RUN);
    assign timeout = (state == S_TIMEOUT);

endmodule

// File: tb/tb_test_aggregator.sv
// Self-checking bench for test_aggregator: directed scenarios plus randomized
// runs compared against a per-edge behavioural model.
module tb_test_aggregator;

    localparam int NT   = 4;
    localparam int TO   = 16;
    localparam int CW   = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NT-1:0] fail = '0;
    logic [NT-1:0] finish = '0;
    logic [NT-1:0] fail_mask;
    logic [NT-1:0] finish_mask;
    logic          first_fail_valid;
    logic [1:0]    first_fail_idx;
    logic [CW-1:0] cycles;
    logic          done;
    logic          pass;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit [NT-1:0] m_fin, m_fail;
    bit          m_ffv, m_done, m_pass, m_to;
    int          m_ffi;
    longint      m_cycles;

    test_aggregator #(
        .NUM_TESTS      (NT),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fail             (fail),
        .finish           (finish),
        .fail_mask        (fail_mask),
        .finish_mask      (finish_mask),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .cycles           (cycles),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the intended behaviour, from the block's rules.
    task automatic model_edge(input bit rst, input bit [NT-1:0] f, input bit [NT-1:0] fi);
        if (rst) begin
            m_fin = '0; m_fail = '0; m_ffv = 0; m_ffi = 0;
            m_done = 0; m_pass = 0; m_to = 0; m_cycles = 0;
        end else if (!m_done) begin
            if (!m_ffv && f != 0) begin
                m_ffv = 1;
                for (int i = 0; i < NT; i++) if (f[i]) begin m_ffi = i; break; end
            end
            m_fin  = m_fin | fi;
            m_fail = m_fail | f;
            m_cycles++;
            if (m_fin == {NT{1'b1}}) begin
                m_done = 1;
                m_pass = (m_fail == 0);
            end else if (m_cycles == TO) begin
                m_done = 1;
                m_to   = 1;
            end
        end
    endtask

    task automatic check_all();
        check("fail_mask", 64'(fail_mask), 64'(m_fail));
        check("finish_mask", 64'(finish_mask), 64'(m_fin));
        check("first_fail_valid", 64'(first_fail_valid), 64'(m_ffv));
        check("first_fail_idx", 64'(first_fail_idx), 64'(m_ffi));
        check("cycles", 64'(cycles), 64'(m_cycles));
        check("done", 64'(done), 64'(m_done));
        check("pass", 64'(pass), 64'(m_pass));
        check("timeout", 64'(timeout), 64'(m_to));
    endtask

    task automatic step(input bit rst, input bit [NT-1:0] f, input bit [NT-1:0] fi);
        reset  = rst;
        fail   = f;
        finish = fi;
        model_edge(rst, f, fi);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 4'hF, 4'hF);
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // all finish on first edge
        step(0, 4'h0, 4'hF);
        check("s1_pass", 64'(pass), 64'd1);
        check("s1_cycles", 64'(cycles), 64'd1);

        // staggered finishes, test 2 fails with its finish
        do_reset();
        step(0, 4'h0, 4'h1);
        step(0, 4'h0, 4'h2);
        step(0, 4'h4, 4'h4);
        step(0, 4'h0, 4'h8);
        check("s2_mask", 64'(fail_mask), 64'h4);
        check("s2_idx", 64'(first_fail_idx), 64'd2);
        check("s2_cycles", 64'(cycles), 64'd4);
        check("s2_pass", 64'(pass), 64'd0);

        // simultaneous failures, lowest index wins; later failure ignored
        do_reset();
        step(0, 4'hA, 4'h0);
        step(0, 4'h1, 4'h0);
        step(0, 4'h0, 4'hF);
        check("s3_idx", 64'(first_fail_idx), 64'd1);
        check("s3_mask", 64'(fail_mask), 64'hB);
        step(0, 4'h4, 4'h0);
        check("s3_idx_hold", 64'(first_fail_idx), 64'd1);

        // timeout; later fails are ignored
        do_reset();
        for (int i = 0; i < TO; i++) step(0, 4'h0, 4'h7);
        check("s4_timeout", 64'(timeout), 64'd1);
        check("s4_cycles", 64'(cycles), 64'd16);
        for (int i = 0; i < 3; i++) step(0, 4'hF, 4'h7);
        check("s4_mask", 64'(fail_mask), 64'h0);

        // last finish on the final edge: DONE wins
        do_reset();
        for (int i = 0; i < TO - 1; i++) step(0, 4'h0, 4'h7);
        step(0, 4'h0, 4'h8);
        check("s5_timeout", 64'(timeout), 64'd0);
        check("s5_pass", 64'(pass), 64'd1);

        // mid-run reset then a clean run
        do_reset();
        step(0, 4'h1, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 4'h0);
        do_reset();
        check("s6_mask", 64'(fail_mask), 64'h0);
        step(0, 4'h0, 4'hF);
        check("s6_pass", 64'(pass), 64'd1);
        check("s6_cycles", 64'(cycles), 64'd1);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int c = 0; c < 24; c++) begin
                bit [NT-1:0] rf, rfi;
                rf  = ($urandom_range(0, 5) == 0) ? NT'($urandom_range(0, 15)) : '0;
                rfi = '0;
                for (int b = 0; b < NT; b++) rfi[b] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 60) == 0) step(1, rf, rfi);
                else step(0, rf, rfi);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
